// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: dimensions, pixel format, fill command and fill FSM states.
// The VGA scan-out uses the same pixel_t and dimensions.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 214;
    localparam int unsigned FB_HEIGHT = 160;
    localparam int unsigned FB_ADDR_W = 16;

    typedef logic [2:0]           pixel_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        pixel_t     color;
    } fill_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRAW
    } fill_state_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle address walker: steps column/line counters and the linear write address
// row-major through a clipped rectangle, using only additions.
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [8:0] x_end_i,
    input  logic [8:0] y_end_i,
    input  fb_addr_t   row_addr_i,
    output fb_addr_t   cur_addr_o,
    output logic       last_o
);

    logic [7:0] col_q, col_d;
    logic [7:0] line_q, line_d;
    fb_addr_t   row_addr_q, row_addr_d;
    fb_addr_t   cur_addr_q, cur_addr_d;
    logic       col_last, line_last;

    assign col_last   = ({1'b0, col_q} + 9'd1) >= x_end_i;
    assign line_last  = ({1'b0, line_q} + 9'd1) >= y_end_i;
    assign last_o     = col_last & line_last;
    assign cur_addr_o = cur_addr_q;

    always_comb begin
        col_d      = col_q;
        line_d     = line_q;
        row_addr_d = row_addr_q;
        cur_addr_d = cur_addr_q;
        if (load_i) begin
            col_d      = x_i;
            line_d     = y_i;
            row_addr_d = row_addr_i;
            cur_addr_d = row_addr_i;
        end else if (step_i) begin
            if (!col_last) begin
                col_d      = col_q + 8'd1;
                cur_addr_d = cur_addr_q + fb_addr_t'(1);
            end else if (!line_last) begin
                // Next line start is the previous line start plus one stride.
                line_d     = line_q + 8'd1;
                col_d      = x_i;
                row_addr_d = row_addr_q + fb_addr_t'(FB_WIDTH);
                cur_addr_d = row_addr_q + fb_addr_t'(FB_WIDTH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            line_q     <= '0;
            row_addr_q <= '0;
            cur_addr_q <= '0;
        end else begin
            col_q      <= col_d;
            line_q     <= line_d;
            row_addr_q <= row_addr_d;
            cur_addr_q <= cur_addr_d;
        end
    end

endmodule

// File: rtl/fb_fill.sv
// Framebuffer rectangle-fill engine: accepts one fill command over valid/ready and streams
// one clipped framebuffer write per cycle, honouring write-port stalls.
module fb_fill
    import fb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n_async,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [7:0]     cmd_x,
    input  logic [7:0]     cmd_y,
    input  logic [7:0]     cmd_w,
    input  logic [7:0]     cmd_h,
    input  logic [2:0]     cmd_color,
    output logic           busy,
    output logic           done,
    output logic           fb_we,
    input  logic           fb_wready,
    output logic [15:0]    fb_waddr,
    output logic [2:0]     fb_wdata
);

    fill_state_t state_q, state_d;
    fill_cmd_t   cmd_q;
    logic        done_q, done_d;
    logic        accept, wr_acc, empty, walk_last;
    logic [8:0]  x_sum, y_sum, x_end, y_end;
    fb_addr_t    row_addr, cur_addr;

    assign accept = cmd_valid & cmd_ready;
    assign wr_acc = fb_we & fb_wready;

    // Setup arithmetic; cmd_q is stable for the whole command so these stay valid through DRAW.
    assign x_sum    = {1'b0, cmd_q.x} + {1'b0, cmd_q.w};
    assign y_sum    = {1'b0, cmd_q.y} + {1'b0, cmd_q.h};
    assign x_end    = (x_sum > 9'(FB_WIDTH))  ? 9'(FB_WIDTH)  : x_sum;
    assign y_end    = (y_sum > 9'(FB_HEIGHT)) ? 9'(FB_HEIGHT) : y_sum;
    assign row_addr = fb_addr_t'(cmd_q.y) * fb_addr_t'(FB_WIDTH) + fb_addr_t'(cmd_q.x);
    assign empty    = (cmd_q.w == 8'd0) || (cmd_q.h == 8'd0) ||
                      ({1'b0, cmd_q.x} >= 9'(FB_WIDTH)) || ({1'b0, cmd_q.y} >= 9'(FB_HEIGHT));

    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (fb_wready && walk_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        fb_we     = (state_q == ST_DRAW);
        fb_waddr  = fb_we ? cur_addr : '0;
        fb_wdata  = fb_we ? cmd_q.color : '0;
    end

    fb_rect_walker u_walker (
        .clk        (clk),
        .rst_n      (rst_n_async),
        .load_i     (state_q == ST_SETUP),
        .step_i     (wr_acc),
        .x_i        (cmd_q.x),
        .y_i        (cmd_q.y),
        .x_end_i    (x_end),
        .y_end_i    (y_end),
        .row_addr_i (row_addr),
        .cur_addr_o (cur_addr),
        .last_o     (walk_last)
    );

endmodule

// File: tb/tb_fb_fill.sv
// Self-checking bench for fb_fill: a rectangle model builds the expected write list,
// a compare process checks every write, and directed tests pin timing and boundaries.
module tb_fb_fill;

    localparam int FBW   = 214;
    localparam int FBH   = 160;
    localparam int LIMIT = 40000;

    logic       clk = 1'b0;
    logic       rst_n_async = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [2:0] cmd_color = '0;
    logic       busy, done, fb_we;
    logic       fb_wready = 1'b1;
    logic [15:0] fb_waddr;
    logic [2:0] fb_wdata;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   exp_color = 0;
    int   acc_cnt = 0;
    bit   rand_mode = 1'b0;
    int   dc, bc, fc, fa, fd, wcyc;

    fb_fill dut (
        .clk         (clk),
        .rst_n_async (rst_n_async),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .busy        (busy),
        .done        (done),
        .fb_we       (fb_we),
        .fb_wready   (fb_wready),
        .fb_waddr    (fb_waddr),
        .fb_wdata    (fb_wdata)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected writes: every pixel of the rectangle clipped to the screen, row-major.
    task automatic model_fill(input int x, input int y, input int w, input int h, input int c);
        int xe, ye;
        exp_q.delete();
        exp_color = c;
        xe = (x + w < FBW) ? x + w : FBW;
        ye = (y + h < FBH) ? y + h : FBH;
        for (int l = y; l < ye; l++)
            for (int cc = x; cc < xe; cc++)
                exp_q.push_back(l * FBW + cc);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        fb_wready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Every presented write must match the head of the expected list, stalled or not.
    initial forever begin
        @(negedge clk);
        if (fb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", fb_waddr);
            end else begin
                chk("waddr", int'(fb_waddr), exp_q[0]);
                chk("wdata", int'(fb_wdata), exp_color);
                if (fb_wready) begin
                    exp_q.delete(0);
                    acc_cnt++;
                end
            end
        end
    end

    task automatic send_cmd(input int x, input int y, input int w, input int h, input int c);
        @(posedge clk);
        #1;
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h); cmd_color = 3'(c);
        @(posedge clk);
        #1;
        // Scramble fields after acceptance; the engine must ignore them.
        cmd_valid = 1'b0;
        cmd_x = 8'hA5; cmd_y = 8'h3C; cmd_w = 8'hFF; cmd_h = 8'hFF; cmd_color = 3'b110;
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                           output int done_cyc, output int busy_cyc, output int first_cyc,
                           output int first_addr, output int first_data);
        int cyc;
        model_fill(x, y, w, h, c);
        acc_cnt = 0;
        send_cmd(x, y, w, h, c);
        cyc = 1; busy_cyc = 0; first_cyc = -1; done_cyc = -1; first_addr = -1; first_data = -1;
        while (cyc < LIMIT) begin
            @(negedge clk);
            #1;
            if (busy) busy_cyc++;
            if (fb_we && first_cyc < 0) begin
                first_cyc  = cyc;
                first_addr = int'(fb_waddr);
                first_data = int'(fb_wdata);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            cyc++;
        end
        if (done_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        end else begin
            chk("writes_left_at_done", exp_q.size(), 0);
            chk("ready_at_done", int'(cmd_ready), 1);
            @(negedge clk);
            #1;
            chk("done_one_cycle", int'(done), 0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_fb_we"},     int'(fb_we), 0);
        chk({tag, "_fb_waddr"},  int'(fb_waddr), 0);
        chk({tag, "_fb_wdata"},  int'(fb_wdata), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n_async = 1'b1;

        // 1x1 at origin
        run_cmd(0, 0, 1, 1, 3'b101, dc, bc, fc, fa, fd);
        chk("t1_first_cycle", fc, 2);
        chk("t1_first_addr", fa, 0);
        chk("t1_first_data", fd, 5);
        chk("t1_done_cycle", dc, 3);
        chk("t1_busy_cycles", bc, 2);

        // Bottom-right corner clip
        model_fill(212, 159, 3, 2, 3);
        chk("t2_model_n", exp_q.size(), 2);
        chk("t2_model_a0", exp_q[0], 34238);
        chk("t2_model_a1", exp_q[1], 34239);
        run_cmd(212, 159, 3, 2, 3'b011, dc, bc, fc, fa, fd);
        chk("t2_first_addr", fa, 34238);
        chk("t2_done_cycle", dc, 4);

        // Empty and fully clipped commands
        run_cmd(5, 5, 0, 7, 3'b111, dc, bc, fc, fa, fd);
        chk("t3_done_cycle", dc, 2);
        chk("t3_busy_cycles", bc, 1);
        chk("t3_no_write", fc, -1);
        run_cmd(5, 5, 7, 0, 3'b111, dc, bc, fc, fa, fd);
        chk("t3h_done_cycle", dc, 2);
        run_cmd(214, 3, 4, 4, 3'b001, dc, bc, fc, fa, fd);
        chk("t3x_done_cycle", dc, 2);
        chk("t3x_no_write", fc, -1);
        run_cmd(0, 160, 4, 4, 3'b001, dc, bc, fc, fa, fd);
        chk("t3y_done_cycle", dc, 2);

        // Full screen
        model_fill(0, 0, 214, 160, 2);
        chk("t4_model_n", exp_q.size(), 34240);
        run_cmd(0, 0, 214, 160, 3'b010, dc, bc, fc, fa, fd);
        chk("t4_first_addr", fa, 0);
        chk("t4_writes", acc_cnt, 34240);
        chk("t4_done_cycle", dc, 34242);

        // Random write-port stalls
        model_fill(10, 20, 4, 3, 4);
        chk("t5_model_a0", exp_q[0], 4290);
        chk("t5_model_a4", exp_q[4], 4504);
        chk("t5_model_a11", exp_q[11], 4721);
        rand_mode = 1'b1;
        run_cmd(10, 20, 4, 3, 3'b100, dc, bc, fc, fa, fd);
        rand_mode = 1'b0;
        chk("t5_writes", acc_cnt, 12);
        chk("t5_first_addr", fa, 4290);
        chk("t5_done_not_early", int'(dc >= 14), 1);

        // Reset during the 10th write of a 5x5
        model_fill(30, 40, 5, 5, 6);
        acc_cnt = 0;
        send_cmd(30, 40, 5, 5, 6);
        wcyc = 0;
        while (acc_cnt < 9 && wcyc < 100) begin
            @(negedge clk);
            #1;
            wcyc++;
        end
        chk("t6_reached_9", acc_cnt, 9);
        @(posedge clk);
        #2;
        chk("t6_we_before_reset", int'(fb_we), 1);
        chk("t6_addr_before_reset", int'(fb_waddr), 41 * FBW + 34);
        rst_n_async = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("t6_async");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("t6_hold");
        chk("t6_writes", acc_cnt, 9);
        rst_n_async = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_no_busy", int'(busy), 0);
        run_cmd(1, 0, 1, 1, 3'b001, dc, bc, fc, fa, fd);
        chk("t6_post_addr", fa, 1);
        chk("t6_post_data", fd, 1);
        chk("t6_post_done_cycle", dc, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_fill.md
# fb_fill

Framebuffer rectangle-fill engine: the write-side counterpart of the VGA scan-out. Accepts one fill command at a time (origin, size, 3-bit colour) over a valid/ready handshake. Streams one framebuffer write per cycle into the 214x160, 3-bit-per-pixel framebuffer, clipping to its bounds. Sits between the CPU/GPU command path and the framebuffer write port; the VGA block reads the same memory on the other port.

## Interface
- FB_WIDTH, 214, pixels per framebuffer line
- FB_HEIGHT, 160, lines per framebuffer
- clk  in  1  system clock (50MHz)
- rst_n_async  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command (high only in IDLE)
- cmd_x  in  8  left column of rectangle
- cmd_y  in  8  top line of rectangle
- cmd_w  in  8  width in pixels (0 = nothing drawn)
- cmd_h  in  8  height in lines (0 = nothing drawn)
- cmd_color  in  3  pixel value {r,g,b}
- busy  out  1  high in SETUP and DRAW
- done  out  1  one-cycle pulse when a command completes
- fb_we  out  1  write request
- fb_wready  in  1  framebuffer accepts write this cycle (arbitration stall)
- fb_waddr  out  16  linear address, line*FB_WIDTH + column
- fb_wdata  out  3  pixel value

## Operation
- States: IDLE, SETUP, DRAW.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, register all cmd_* fields; go to SETUP.
- SETUP (exactly 1 cycle):
  - Compute x_end = min(x+w, FB_WIDTH) and y_end = min(y+h, FB_HEIGHT), using 9-bit sums.
  - Compute row_addr = y*FB_WIDTH + x as a constant multiply, 16 bits.
  - If w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT: go to IDLE and pulse done with no writes.
  - Otherwise load col=x, line=y, cur_addr=row_addr; go to DRAW.
- DRAW: fb_we=1, fb_waddr=cur_addr, fb_wdata=colour. A write is accepted on a cycle with fb_we & fb_wready.
  - On acceptance, if col+1 < x_end: col++, cur_addr++.
  - Else, if line+1 < y_end: line++, col=x, row_addr+=FB_WIDTH, cur_addr=row_addr+FB_WIDTH.
  - Else: go to IDLE and pulse done.
  - While fb_wready=0, fb_waddr, fb_wdata and fb_we are held stable.
- No multiply or divide inside DRAW; row stepping is by addition only.
- Addresses written are exactly the clipped rectangle, row-major, each exactly once.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, fb_we=0, fb_waddr=0, fb_wdata=0; state=IDLE.
- Reset mid-operation abandons the command immediately, with no further writes.
- Command accepted at edge E0. SETUP occupies the cycle after E0. First fb_we occurs in the cycle after SETUP (2 cycles after acceptance).
- Throughput is 1 pixel/cycle when fb_wready=1. A command of N clipped pixels with no stalls takes 2+N cycles from acceptance to done.
- done is high for one cycle, in the cycle after the last accepted write (state IDLE, cmd_ready=1). A new command may be accepted in that same cycle.
- An empty or fully-clipped command pulses done in the cycle after SETUP.
- cmd_* are sampled only at acceptance; changes while busy are ignored.

## Structure
- Shared package fb_pkg:
  - FB_WIDTH, FB_HEIGHT, FB_ADDR_W=16
  - typedef pixel_t (3-bit)
  - typedef fill_cmd_t (packed struct x, y, w, h, color)
  - enum fill_state_t. The VGA block uses the same pixel_t and dimensions.
- Optional sub-module fb_rect_walker: col/line/cur_addr/row_addr counters with step/load inputs. The FSM and handshake stay in fb_fill.

## Test plan
- 1x1 at (0,0), colour 3'b101 -> single write addr 0 data 5 two cycles after accept; done the next cycle.
- 3x2 at (212,159) -> clipped to 2x1: writes at 34238, 34239 only; done.
- w=0 at (5,5) -> no fb_we; done in the cycle after SETUP; busy high for exactly one cycle.
- Full screen (0,0,214,160), fb_wready=1 -> 34240 writes at contiguous addresses 0..34239; done 34242 cycles after accept.
- 4x3 at (10,20) with fb_wready pseudo-random 50% -> 12 writes at 4290..4293, 4504..4507, 4718..4721; address/data stable while stalled; no duplicates.
- Assert rst_n_async low during the 10th write of a 5x5 -> all outputs reset asynchronously. After release, 1x1 at (1,0) writes addr 1 correctly.
